prio_rr_arbiter: RTL and testbench
==================================

// Module: prio_rr_arbiter
// PURPOSE
//  Registered N-way request arbiter, successor to the combinational priority encoders.
//  Issues a one-hot grant plus binary code (index+1, 0 = none) and holds it until release.
//  Supports fixed-priority (highest index wins) or round-robin mode; max-hold timeout.
//  Sits in front of shared resources (bus masters, FSM-driven shared units).
// PARAMETERS
//  N_REQ    4   number of requesters, >= 2
//  RR_MODE  0   0 = fixed priority (highest index wins), 1 = round robin
//  MAX_HOLD 16  max cycles a grant is held before forced release; 0 = timeout disabled
//  CODE_W   $clog2(N_REQ+1) localparam, width of grant_code
// PORTS
//  clock       in   1       single clock, all logic on posedge
//  reset       in   1       synchronous, active-high; dominates all other inputs
//  req         in   N_REQ   request vector, level-sensitive, held until granted
//  done        in   1       owner finished; releases grant at this edge (ignored in IDLE)
//  grant       out  N_REQ   one-hot grant, registered, all-zero when idle
//  grant_code  out  CODE_W  owner index + 1; 0 = no grant
//  busy        out  1       1 while a grant is held (state BUSY)
//  timeout     out  1       1-cycle pulse, cycle after a forced (MAX_HOLD) release
// BEHAVIOUR
//  Reset: grant=0, grant_code=0, busy=0, timeout=0, state=IDLE, hold_cnt=0.
//   Last-owner pointer = N_REQ-1, so the first RR search starts at index 0.
//  States (one-hot encoded): IDLE, BUSY.
//  IDLE: if req!=0 at edge k, winner granted at edge k (visible cycle k+1) -> BUSY.
//  Winner: fixed mode = highest set index. RR mode = first set bit searching
//   owner+1, owner+2, ... with wrap N_REQ-1 -> 0.
//  BUSY release at an edge when any of:
//   a) done=1
//   b) req[owner]=0
//   c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
//  hold_cnt: cleared on every new grant, +1 per BUSY cycle, saturates, never wraps.
//  Releasing owner is excluded from the arbitration at the release edge (both modes).
//  If another req is eligible, it is granted on the same edge: back-to-back, no idle cycle.
//   hold_cnt clears; the pointer updates to the new owner.
//  Otherwise -> IDLE and grant=0. The excluded owner may win again from the next cycle.
//  timeout=1 only for release cause (c) alone. If done or a req drop coincides with
//   the hold limit, the release is normal and timeout=0.
//  grant/grant_code/busy always mutually consistent; at most one grant bit set.
//  req changes of non-owners during BUSY do not affect grant until release.
//  Reset asserted mid-BUSY: next cycle all outputs at reset values, pointer re-initialised.
// TESTING
//  1 Fixed, N=4: req=4'b0011 from IDLE -> next cycle grant=0010, code=2, busy=1.
//    Release, then req=4'b1010 -> grant=1000, code=4.
//  2 RR: req=4'b1111 held, done pulsed 1 cycle after each grant.
//    -> codes 1,2,3,4,1 on consecutive grants; busy stays 1, no idle gap.
//  3 MAX_HOLD=16, req=4'b0001 held, no done -> grant held exactly 16 cycles.
//    Then grant=0, timeout=1 for one cycle; 1 IDLE cycle; then re-granted, code=1.
//  4 Owner 2 drops req while BUSY, req[3]=1 -> grant moves to 1000 at that edge.
//    Check timeout=0.
//  5 reset pulsed mid-BUSY with req=1111 (RR) -> grant=0, code=0, busy=0 next cycle.
//    After release, first grant = index 0.
//  6 done in IDLE with req=0 -> no change.
//    done coincident with hold limit -> normal release, timeout=0.

Source files
------------

// File: rtl/prio_rr_arbiter.sv
// Registered N-way request arbiter with a one-hot grant and a binary owner code.
// The winner is picked either by fixed priority (highest index wins) or by round robin
// starting after the last owner. A grant is held until the owner signals done, drops
// its request, or reaches the optional maximum hold time. On release, the next eligible
// requester is granted on the same edge, so there is no idle cycle between owners.
module prio_rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 16,
    localparam int CODE_W  = $clog2(N_REQ + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req,
    input  logic              done,
    output logic [N_REQ-1:0]  grant,
    output logic [CODE_W-1:0] grant_code,
    output logic              busy,
    output logic              timeout
);

    localparam int OWN_W = $clog2(N_REQ);
    localparam int HC_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST  = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [OWN_W-1:0] OWNER_INIT = OWN_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_BUSY = 2'b10
    } state_t;

    state_t              r_state;
    logic [N_REQ-1:0]    r_grant;
    logic [CODE_W-1:0]   r_code;
    logic [OWN_W-1:0]    r_owner;
    logic [HC_W-1:0]     r_hold;
    logic                r_timeout;

    state_t              w_stateNext;
    logic [N_REQ-1:0]    w_grantNext;
    logic [CODE_W-1:0]   w_codeNext;
    logic [OWN_W-1:0]    w_ownerNext;
    logic [HC_W-1:0]     w_holdNext;
    logic                w_timeoutNext;

    logic [N_REQ-1:0]    w_ownerMask;
    logic [N_REQ-1:0]    w_cand;
    logic [N_REQ-1:0]    w_rot;
    logic [2*N_REQ-1:0]  w_dbl;
    logic                w_found;
    logic [OWN_W-1:0]    w_winner;
    int                  w_rrOffset;
    int                  w_rrIdx;

    logic                w_relDone;
    logic                w_relDrop;
    logic                w_relTimeout;
    logic                w_release;

    assign w_ownerMask  = N_REQ'(1) << r_owner;
    assign w_relDone    = done;
    assign w_relDrop    = ((req & w_ownerMask) == '0);
    assign w_relTimeout = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);
    assign w_release    = w_relDone | w_relDrop | w_relTimeout;

    // Pick a winner among eligible requesters; the current owner is masked out while busy
    // so that a releasing owner can never immediately re-win on its own release edge.
    always_comb begin
        w_cand = req;
        if (r_state == ST_BUSY) begin
            w_cand = req & ~w_ownerMask;
        end
        w_found    = (w_cand != '0);
        w_winner   = '0;
        w_dbl      = {w_cand, w_cand};
        w_rot      = '0;
        w_rrOffset = 0;
        w_rrIdx    = 0;
        if (RR_MODE != 0) begin
            w_rot = N_REQ'(w_dbl >> (int'(r_owner) + 1));
            for (int j = N_REQ - 1; j >= 0; j--) begin
                if ((w_rot & (N_REQ'(1) << j)) != '0) begin
                    w_rrOffset = j;
                end
            end
            w_rrIdx = int'(r_owner) + 1 + w_rrOffset;
            if (w_rrIdx >= N_REQ) begin
                w_rrIdx = w_rrIdx - N_REQ;
            end
            w_winner = OWN_W'(w_rrIdx);
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if ((w_cand & (N_REQ'(1) << i)) != '0) begin
                    w_winner = OWN_W'(i);
                end
            end
        end
    end

    // Next-state logic: grant from IDLE, hold or hand over while BUSY, flag forced releases.
    always_comb begin
        w_stateNext   = r_state;
        w_grantNext   = r_grant;
        w_codeNext    = r_code;
        w_ownerNext   = r_owner;
        w_holdNext    = r_hold;
        w_timeoutNext = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_stateNext = ST_BUSY;
                    w_grantNext = N_REQ'(1) << w_winner;
                    w_codeNext  = CODE_W'(w_winner) + CODE_W'(1);
                    w_ownerNext = w_winner;
                    w_holdNext  = '0;
                end
            end
            ST_BUSY: begin
                if (w_release) begin
                    w_timeoutNext = w_relTimeout & ~w_relDone & ~w_relDrop;
                    w_holdNext    = '0;
                    if (w_found) begin
                        w_grantNext = N_REQ'(1) << w_winner;
                        w_codeNext  = CODE_W'(w_winner) + CODE_W'(1);
                        w_ownerNext = w_winner;
                    end else begin
                        w_stateNext = ST_IDLE;
                        w_grantNext = '0;
                        w_codeNext  = '0;
                    end
                end else if (r_hold != '1) begin
                    w_holdNext = r_hold + HC_W'(1);
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_grantNext = '0;
                w_codeNext  = '0;
                w_holdNext  = '0;
            end
        endcase
    end

    // State and output registers; reset re-initialises the pointer so the next RR search starts at 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_code    <= '0;
            r_owner   <= OWNER_INIT;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_grant   <= w_grantNext;
            r_code    <= w_codeNext;
            r_owner   <= w_ownerNext;
            r_hold    <= w_holdNext;
            r_timeout <= w_timeoutNext;
        end
    end

    assign grant      = r_grant;
    assign grant_code = r_code;
    assign busy       = (r_state == ST_BUSY);
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Bench for prio_rr_arbiter: one fixed-priority and one round-robin instance, both N=4,
// MAX_HOLD=16, driven from vector tables plus hand-written hold-limit sequences.
module tb_prio_rr_arbiter;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] expGrant;
        logic [2:0] expCode;
        logic       expBusy;
        logic       expTimeout;
    } vec_t;

    logic       clock;
    logic       rstF, doneF, busyF, timeoutF;
    logic [3:0] reqF, grantF;
    logic [2:0] codeF;
    logic       rstR, doneR, busyR, timeoutR;
    logic [3:0] reqR, grantR;
    logic [2:0] codeR;

    int testsRun  = 0;
    int failCount = 0;

    vec_t fixedVecs[16];
    vec_t rrVecs[15];

    prio_rr_arbiter #(.N_REQ(4), .RR_MODE(0), .MAX_HOLD(16)) dutFixed (
        .clock(clock), .reset(rstF), .req(reqF), .done(doneF),
        .grant(grantF), .grant_code(codeF), .busy(busyF), .timeout(timeoutF)
    );

    prio_rr_arbiter #(.N_REQ(4), .RR_MODE(1), .MAX_HOLD(16)) dutRr (
        .clock(clock), .reset(rstR), .req(reqR), .done(doneR),
        .grant(grantR), .grant_code(codeR), .busy(busyR), .timeout(timeoutR)
    );

    // Free-running clock shared by both instances.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic applyStimulus(input int sel, input logic rst, input logic [3:0] req, input logic done);
        if (sel == 0) begin
            rstF = rst; reqF = req; doneF = done;
        end else begin
            rstR = rst; reqR = req; doneR = done;
        end
    endtask

    task automatic stepClock();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int sel, input logic [3:0] eg,
                               input logic [2:0] ec, input logic eb, input logic et);
        logic [3:0] g;
        logic [2:0] c;
        logic       b, t;
        if (sel == 0) begin
            g = grantF; c = codeF; b = busyF; t = timeoutF;
        end else begin
            g = grantR; c = codeR; b = busyR; t = timeoutR;
        end
        testsRun++;
        if (g !== eg || c !== ec || b !== eb || t !== et) begin
            failCount++;
            $display("[TB] FAIL %s: got grant=%b code=%0d busy=%b timeout=%b, expected grant=%b code=%0d busy=%b timeout=%b",
                     tag, g, c, b, t, eg, ec, eb, et);
        end
    endtask

    // Main sequence: vector tables first, then the multi-cycle hold-limit cases.
    initial begin
        applyStimulus(0, 1'b1, 4'b0000, 1'b0);
        applyStimulus(1, 1'b1, 4'b0000, 1'b0);

        // Fixed priority: {rst, req, done, grant, code, busy, timeout}
        fixedVecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0};
        fixedVecs[1]  = '{1'b0, 4'b0011, 1'b0, 4'b0010, 3'd2, 1'b1, 1'b0};
        fixedVecs[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0};
        fixedVecs[3]  = '{1'b0, 4'b1010, 1'b0, 4'b1000, 3'd4, 1'b1, 1'b0};
        fixedVecs[4]  = '{1'b0, 4'b1010, 1'b0, 4'b1000, 3'd4, 1'b1, 1'b0};
        fixedVecs[5]  = '{1'b0, 4'b1011, 1'b0, 4'b1000, 3'd4, 1'b1, 1'b0};
        fixedVecs[6]  = '{1'b0, 4'b1110, 1'b1, 4'b0100, 3'd3, 1'b1, 1'b0};
        fixedVecs[7]  = '{1'b0, 4'b1110, 1'b0, 4'b0100, 3'd3, 1'b1, 1'b0};
        fixedVecs[8]  = '{1'b0, 4'b1010, 1'b0, 4'b1000, 3'd4, 1'b1, 1'b0};
        fixedVecs[9]  = '{1'b0, 4'b1000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0};
        fixedVecs[10] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 3'd4, 1'b1, 1'b0};
        fixedVecs[11] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0};
        fixedVecs[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0};
        fixedVecs[13] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0};
        fixedVecs[14] = '{1'b1, 4'b0110, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0};
        fixedVecs[15] = '{1'b0, 4'b0110, 1'b0, 4'b0100, 3'd3, 1'b1, 1'b0};

        // Round robin: consecutive handovers, reset mid-busy, pointer wrap and exclusion
        rrVecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0};
        rrVecs[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 3'd1, 1'b1, 1'b0};
        rrVecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 3'd2, 1'b1, 1'b0};
        rrVecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 3'd3, 1'b1, 1'b0};
        rrVecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 3'd4, 1'b1, 1'b0};
        rrVecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 3'd1, 1'b1, 1'b0};
        rrVecs[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 3'd1, 1'b1, 1'b0};
        rrVecs[7]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0};
        rrVecs[8]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 3'd1, 1'b1, 1'b0};
        rrVecs[9]  = '{1'b0, 4'b0101, 1'b1, 4'b0100, 3'd3, 1'b1, 1'b0};
        rrVecs[10] = '{1'b0, 4'b0101, 1'b1, 4'b0001, 3'd1, 1'b1, 1'b0};
        rrVecs[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0};
        rrVecs[12] = '{1'b0, 4'b1010, 1'b0, 4'b0010, 3'd2, 1'b1, 1'b0};
        rrVecs[13] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 3'd4, 1'b1, 1'b0};
        rrVecs[14] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 3'd2, 1'b1, 1'b0};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, fixedVecs[i].rst, fixedVecs[i].req, fixedVecs[i].done);
            stepClock();
            checkOutput($sformatf("fixed[%0d]", i), 0, fixedVecs[i].expGrant, fixedVecs[i].expCode,
                        fixedVecs[i].expBusy, fixedVecs[i].expTimeout);
        end

        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, rrVecs[i].rst, rrVecs[i].req, rrVecs[i].done);
            stepClock();
            checkOutput($sformatf("rr[%0d]", i), 1, rrVecs[i].expGrant, rrVecs[i].expCode,
                        rrVecs[i].expBusy, rrVecs[i].expTimeout);
        end

        // Fixed: single requester held with no done is forced off after exactly 16 cycles.
        applyStimulus(0, 1'b1, 4'b0001, 1'b0);
        stepClock();
        checkOutput("holdReset", 0, 4'b0000, 3'd0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 4'b0001, 1'b0);
        stepClock();
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("holdCycle[%0d]", i), 0, 4'b0001, 3'd1, 1'b1, 1'b0);
            stepClock();
        end
        checkOutput("forcedRelease", 0, 4'b0000, 3'd0, 1'b0, 1'b1);
        stepClock();
        checkOutput("regrantAfterTimeout", 0, 4'b0001, 3'd1, 1'b1, 1'b0);

        // Fixed: done on the hold-limit edge is a normal release without timeout.
        repeat (15) stepClock();
        applyStimulus(0, 1'b0, 4'b0001, 1'b1);
        stepClock();
        checkOutput("doneAtLimit", 0, 4'b0000, 3'd0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 4'b0001, 1'b0);
        stepClock();
        checkOutput("regrantAfterDone", 0, 4'b0001, 3'd1, 1'b1, 1'b0);

        // RR: forced release hands over back-to-back and still pulses timeout.
        applyStimulus(1, 1'b0, 4'b0011, 1'b0);
        for (int i = 0; i < 15; i++) begin
            stepClock();
            checkOutput($sformatf("rrHold[%0d]", i), 1, 4'b0010, 3'd2, 1'b1, 1'b0);
        end
        stepClock();
        checkOutput("rrForcedHandover", 1, 4'b0001, 3'd1, 1'b1, 1'b1);
        stepClock();
        checkOutput("rrTimeoutPulseEnds", 1, 4'b0001, 3'd1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
